// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the space invaders video pipeline.
// BULLET_LEN_DEFAULT is also used by color_mapper, so the drawn and logical bullet lengths match.
package space_invaders_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLYING = 2'd1,
      HIT    = 2'd2
   } bullet_state_t;

   localparam int SCREEN_W           = 640;
   localparam int SCREEN_H           = 480;
   localparam int BULLET_LEN_DEFAULT = 4;

   // 8-bit increment that sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/bullet_controller_frame_tick_gen.sv
// Brings the asynchronous vsync level into the Clk domain and emits a one-Clk
// frame_tick on each rising edge.
module frame_tick_gen (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic frame_tick
);

   logic [1:0] sync_reg;
   logic       frame_clk_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_reg    <= 2'b00;
         frame_clk_d <= 1'b0;
      end else begin
         sync_reg    <= {sync_reg[0], frame_clk};
         frame_clk_d <= sync_reg[1];
      end
   end

   assign frame_tick = sync_reg[1] & ~frame_clk_d;

endmodule

// File: rtl/bullet_controller.sv
// Player bullet: launch on fire, advance once per frame, retire when it leaves
// the top of the screen or hits an enemy, followed by a short cooldown.
module bullet_controller
   import space_invaders_pkg::*;
#(
   parameter int BULLET_SPEED    = 4,
   parameter int BULLET_LEN      = BULLET_LEN_DEFAULT,
   parameter int PLAYER_HALF_W   = 8,
   parameter int COOLDOWN_FRAMES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       fire,
   input  logic [9:0] playerX,
   input  logic [9:0] playerY,
   input  logic       collision,
   output logic       bullet_in,
   output logic [9:0] bulletX,
   output logic [9:0] bulletY,
   output logic       hit_pulse,
   output logic [7:0] hit_count
);

   bullet_state_t state_reg, state_next;
   logic [9:0]    bullet_x_reg, bullet_x_next;
   logic [9:0]    bullet_y_reg, bullet_y_next;
   logic          bullet_in_reg, bullet_in_next;
   logic          hit_pulse_reg, hit_pulse_next;
   logic [7:0]    hit_count_reg, hit_count_next;
   logic          fire_req_reg, fire_req_next;
   logic          hit_latch_reg, hit_latch_next;
   logic [7:0]    cooldown_reg, cooldown_next;
   logic          frame_tick;

   frame_tick_gen u_frame_tick_gen (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .frame_tick (frame_tick)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg     <= IDLE;
         bullet_x_reg  <= 10'd0;
         bullet_y_reg  <= 10'd0;
         bullet_in_reg <= 1'b0;
         hit_pulse_reg <= 1'b0;
         hit_count_reg <= 8'd0;
         fire_req_reg  <= 1'b0;
         hit_latch_reg <= 1'b0;
         cooldown_reg  <= 8'd0;
      end else begin
         state_reg     <= state_next;
         bullet_x_reg  <= bullet_x_next;
         bullet_y_reg  <= bullet_y_next;
         bullet_in_reg <= bullet_in_next;
         hit_pulse_reg <= hit_pulse_next;
         hit_count_reg <= hit_count_next;
         fire_req_reg  <= fire_req_next;
         hit_latch_reg <= hit_latch_next;
         cooldown_reg  <= cooldown_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bullet_x_next  = bullet_x_reg;
      bullet_y_next  = bullet_y_reg;
      hit_pulse_next = 1'b0;
      hit_count_next = hit_count_reg;
      fire_req_next  = fire_req_reg;
      hit_latch_next = hit_latch_reg;
      cooldown_next  = cooldown_reg;

      unique case (state_reg)
         IDLE: begin
            if (frame_tick && (fire_req_reg || fire)) begin
               bullet_x_next  = playerX + 10'(PLAYER_HALF_W);
               bullet_y_next  = (playerY < 10'(BULLET_LEN)) ? 10'd0 : playerY - 10'(BULLET_LEN);
               hit_latch_next = 1'b0;
               fire_req_next  = 1'b0;
               state_next     = FLYING;
            end else if (fire) begin
               fire_req_next = 1'b1;
            end
         end
         FLYING: begin
            fire_req_next  = 1'b0;
            hit_latch_next = hit_latch_reg | collision;
            // A collision on the tick cycle itself still belongs to the closing frame.
            if (frame_tick) begin
               if (hit_latch_reg || collision) begin
                  state_next     = HIT;
                  hit_pulse_next = 1'b1;
                  hit_count_next = sat_inc8(hit_count_reg);
                  cooldown_next  = 8'(COOLDOWN_FRAMES);
               end else if (bullet_y_reg < 10'(BULLET_SPEED)) begin
                  state_next = IDLE;
               end else begin
                  bullet_y_next = bullet_y_reg - 10'(BULLET_SPEED);
               end
            end
         end
         HIT: begin
            fire_req_next = 1'b0;
            if (frame_tick) begin
               if (cooldown_reg <= 8'd1) begin
                  state_next = IDLE;
               end else begin
                  cooldown_next = cooldown_reg - 8'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      bullet_in_next = (state_next == FLYING);
   end

   assign bullet_in = bullet_in_reg;
   assign bulletX   = bullet_x_reg;
   assign bulletY   = bullet_y_reg;
   assign hit_pulse = hit_pulse_reg;
   assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_bullet_controller.sv
// Self-checking bench for bullet_controller: directed vector table, tick-cycle and
// reset corner cases, saturation, and random frames against a frame-level model.
module tb_bullet_controller;

   localparam int SPEED = 4;
   localparam int LEN   = 4;
   localparam int HALF  = 8;
   localparam int COOL  = 2;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic       fire = 1'b0;
   logic [9:0] playerX = 10'd0;
   logic [9:0] playerY = 10'd0;
   logic       collision = 1'b0;
   logic       bullet_in;
   logic [9:0] bulletX;
   logic [9:0] bulletY;
   logic       hit_pulse;
   logic [7:0] hit_count;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   bit verbose = 1'b1;

   // Frame-level reference model
   bit m_active;
   bit m_pending;
   bit m_hit;
   int m_x, m_y, m_cool, m_hits, m_pulses;

   typedef struct {
      int fire_mode;   // 0 none, 1 pulse, 2 hold through frame
      bit coll;
      int px;
      int py;
      bit exp_in;
      bit chk_xy;
      int exp_x;
      int exp_y;
      int exp_hc;
   } vec_t;

   vec_t vecs[18];

   bullet_controller dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .fire      (fire),
      .playerX   (playerX),
      .playerY   (playerY),
      .collision (collision),
      .bullet_in (bullet_in),
      .bulletX   (bulletX),
      .bulletY   (bulletY),
      .hit_pulse (hit_pulse),
      .hit_count (hit_count)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (hit_pulse) pulse_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_pending = 0; m_hit = 0;
      m_x = 0; m_y = 0; m_cool = 0; m_hits = 0;
   endtask

   function automatic bit model_idle();
      return !m_active && (m_cool == 0);
   endfunction

   task automatic model_frame();
      if (m_active) begin
         if (m_hit) begin
            m_active = 0;
            m_cool = COOL;
            if (m_hits < 255) m_hits++;
            m_pulses++;
         end else if (m_y < SPEED) begin
            m_active = 0;
         end else begin
            m_y = m_y - SPEED;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (m_pending || fire) begin
         m_active = 1;
         m_hit = 0;
         m_pending = 0;
         m_x = (int'(playerX) + HALF) % 1024;
         m_y = (int'(playerY) >= LEN) ? int'(playerY) - LEN : 0;
      end
      if (model_idle() && fire) m_pending = 1;
   endtask

   task automatic fire_pulse();
      @(negedge Clk) fire = 1'b1;
      @(negedge Clk) fire = 1'b0;
      if (model_idle()) m_pending = 1;
   endtask

   task automatic coll_pulse();
      @(negedge Clk) collision = 1'b1;
      @(negedge Clk) collision = 1'b0;
      if (m_active) m_hit = 1;
   endtask

   // One vsync period; optionally raises collision only on the tick cycle.
   task automatic tick_frame(input bit coll_on_tick);
      frame_clk = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      if (coll_on_tick) collision = 1'b1;
      @(negedge Clk);
      collision = 1'b0;
      if (coll_on_tick && m_active) m_hit = 1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (6) @(negedge Clk);
      model_frame();
      check("frame_bullet_in", int'(bullet_in), int'(m_active));
      if (m_active) begin
         check("frame_bulletX", int'(bulletX), m_x);
         check("frame_bulletY", int'(bulletY), m_y);
      end
      check("frame_hit_count", int'(hit_count), m_hits);
      check("frame_hit_pulses", pulse_cnt, m_pulses);
      if (verbose)
         $display("frame: in=%0d x=%0d y=%0d hits=%0d pulses=%0d",
                  bullet_in, bulletX, bulletY, hit_count, pulse_cnt);
   endtask

   task automatic hit_cycle();
      fire = 1'b1;
      tick_frame(1'b0);
      fire = 1'b0;
      coll_pulse();
      tick_frame(1'b0);
      tick_frame(1'b0);
      tick_frame(1'b0);
   endtask

   initial begin
      int p0;
      vecs[0]  = '{1, 0, 300, 440, 1, 1, 308, 436, 0};
      vecs[1]  = '{0, 0, 300, 440, 1, 1, 308, 432, 0};
      vecs[2]  = '{0, 0, 300, 440, 1, 1, 308, 428, 0};
      vecs[3]  = '{0, 0, 300, 440, 1, 1, 308, 424, 0};
      vecs[4]  = '{0, 1, 300, 440, 0, 0, 0,   0,   1};
      vecs[5]  = '{2, 0, 300, 440, 0, 0, 0,   0,   1};
      vecs[6]  = '{2, 0, 300, 440, 0, 0, 0,   0,   1};
      vecs[7]  = '{2, 0, 300, 440, 1, 1, 308, 436, 1};
      vecs[8]  = '{0, 1, 300, 440, 0, 0, 0,   0,   2};
      vecs[9]  = '{0, 0, 300, 440, 0, 0, 0,   0,   2};
      vecs[10] = '{0, 0, 300, 440, 0, 0, 0,   0,   2};
      vecs[11] = '{1, 0, 300, 10,  1, 1, 308, 6,   2};
      vecs[12] = '{0, 0, 300, 10,  1, 1, 308, 2,   2};
      vecs[13] = '{0, 0, 300, 10,  0, 0, 0,   0,   2};
      vecs[14] = '{0, 1, 300, 10,  0, 0, 0,   0,   2};
      vecs[15] = '{1, 0, 300, 10,  1, 1, 308, 6,   2};
      vecs[16] = '{0, 0, 300, 10,  1, 1, 308, 2,   2};
      vecs[17] = '{0, 0, 300, 10,  0, 0, 0,   0,   2};

      model_reset();
      m_pulses = 0;

      // Reset held with fire high and frame_clk toggling
      fire = 1'b1;
      for (int i = 0; i < 4; i++) begin
         frame_clk = ~frame_clk;
         repeat (3) @(negedge Clk);
      end
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      check("reset_bullet_in", int'(bullet_in), 0);
      check("reset_hit_count", int'(hit_count), 0);
      check("reset_hit_pulse", int'(hit_pulse), 0);
      Reset = 1'b0;
      repeat (5) @(negedge Clk);
      check("post_reset_bullet_in", int'(bullet_in), 0);
      check("post_reset_hit_count", int'(hit_count), 0);
      m_pending = 1;
      fire = 1'b0;
      $display("reset released: in=%0d hits=%0d", bullet_in, hit_count);

      // Directed vector table
      for (int i = 0; i < 18; i++) begin
         playerX = 10'(vecs[i].px);
         playerY = 10'(vecs[i].py);
         if (vecs[i].fire_mode == 1) fire_pulse();
         fire = (vecs[i].fire_mode == 2);
         if (vecs[i].coll) coll_pulse();
         tick_frame(1'b0);
         check($sformatf("vec%0d_bullet_in", i), int'(bullet_in), int'(vecs[i].exp_in));
         if (vecs[i].chk_xy) begin
            check($sformatf("vec%0d_bulletX", i), int'(bulletX), vecs[i].exp_x);
            check($sformatf("vec%0d_bulletY", i), int'(bulletY), vecs[i].exp_y);
         end
         check($sformatf("vec%0d_hit_count", i), int'(hit_count), vecs[i].exp_hc);
      end
      fire = 1'b0;

      // Collision exactly on the tick cycle counts as a hit
      playerY = 10'd440;
      for (int i = 0; i < 4 && !model_idle(); i++) tick_frame(1'b0);
      check("tickcoll_idle_before", int'(model_idle()), 1);
      fire_pulse();
      tick_frame(1'b0);
      check("tickcoll_launched", int'(bullet_in), 1);
      p0 = pulse_cnt;
      tick_frame(1'b1);
      check("tickcoll_bullet_in", int'(bullet_in), 0);
      check("tickcoll_pulse", pulse_cnt - p0, 1);

      // Random frames against the model
      for (int f = 0; f < 120; f++) begin
         playerX = 10'($urandom_range(0, 1023));
         playerY = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12))
                                                : 10'($urandom_range(0, 479));
         case ($urandom_range(0, 3))
            0: fire_pulse();
            1: fire = 1'b1;
            default: fire = 1'b0;
         endcase
         if ($urandom_range(0, 3) == 0) coll_pulse();
         tick_frame($urandom_range(0, 7) == 0);
      end
      fire = 1'b0;
      for (int i = 0; i < 4 && !model_idle(); i++) tick_frame(1'b0);

      // Drive the hit counter to saturation
      verbose = 1'b0;
      playerY = 10'd440;
      for (int i = 0; i < 300 && m_hits < 255; i++) hit_cycle();
      verbose = 1'b1;
      check("sat_preload", int'(hit_count), 255);
      p0 = pulse_cnt;
      hit_cycle();
      check("sat_hit_count", int'(hit_count), 255);
      check("sat_pulse", pulse_cnt - p0, 1);

      // Reset while the bullet is flying
      fire_pulse();
      tick_frame(1'b0);
      check("midflight_active", int'(bullet_in), 1);
      coll_pulse();
      p0 = pulse_cnt;
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk);
      check("midflight_bullet_in", int'(bullet_in), 0);
      check("midflight_hit_count", int'(hit_count), 0);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      repeat (12) @(negedge Clk);
      check("midflight_no_pulse", pulse_cnt - p0, 0);
      check("midflight_still_idle", int'(bullet_in), 0);
      $display("reset mid-flight: in=%0d hits=%0d", bullet_in, hit_count);
      tick_frame(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bullet_controller.md
Name: bullet_controller

Overview:
- Owns the player's single bullet: launches it on fire, advances it once per frame, and retires it when it leaves the screen or hits an enemy.
- Drives bullet_in, bulletX and bulletY into color_mapper.
- Consumes color_mapper's per-pixel collision flag, closing the bullet/collision loop.
- Runs on the 50 MHz Clk and samples frame_clk (VGA vsync) for frame timing.

Parameters:
- BULLET_SPEED, 4: pixels bulletY decreases per frame.
- BULLET_LEN, 4: vertical bullet length in pixels; matches the mapper's drawn length.
- PLAYER_HALF_W, 8: offset from playerX to the bullet launch column.
- COOLDOWN_FRAMES, 2: frames spent in HIT before a new launch is allowed.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- frame_clk  input  1  vsync-rate frame strobe, asynchronous level
- fire  input  1  fire button, level, active-high
- playerX  input  10  player sprite left edge
- playerY  input  10  player sprite top edge
- collision  input  1  per-pixel bullet/enemy overlap from color_mapper
- bullet_in  output  1  bullet visible/active
- bulletX  output  10  bullet column
- bulletY  output  10  bullet top row
- hit_pulse  output  1  one-Clk pulse per confirmed hit
- hit_count  output  8  saturating hit counter

Behaviour:
- Reset (synchronous, active-high): state=IDLE, bullet_in=0, bulletX=0, bulletY=0, hit_pulse=0, hit_count=0, fire_req=0, hit_latch=0, cooldown=0, frame_clk_d=0.
- Frame timing: frame_clk passes through two flops, then a rising-edge detect produces frame_tick. frame_tick is high for one Clk, 3 Clk after the frame_clk edge.
- fire_req:
  - Set when fire=1 while state=IDLE.
  - Cleared on launch.
  - Forced to 0 in FLYING and HIT; fire presses there are dropped, not queued.
- IDLE:
  - bullet_in=0.
  - On frame_tick with (fire_req | fire): launch.
    - bulletX <= playerX + PLAYER_HALF_W, truncated to 10 bits.
    - bulletY <= playerY - BULLET_LEN, saturating at 0.
    - hit_latch <= 0; state <= FLYING.
  - bullet_in=1 from the cycle after the launch tick.
- FLYING:
  - bullet_in=1.
  - hit_latch <= hit_latch | collision on every Clk.
  - On frame_tick, with h = hit_latch | collision (a collision on the tick cycle counts for the closing frame):
    - h=1: state <= HIT; bullet_in <= 0; hit_pulse=1 for that next cycle; hit_count += 1, saturating at 255; cooldown <= COOLDOWN_FRAMES.
    - else if bulletY < BULLET_SPEED: state <= IDLE (off top of screen, no hit).
    - else: bulletY <= bulletY - BULLET_SPEED.
  - bulletX is held constant while FLYING.
- HIT:
  - bullet_in=0; collision is ignored.
  - On frame_tick: if cooldown <= 1, state <= IDLE; else cooldown -= 1.
  - bulletX/bulletY keep their last values (don't-care while bullet_in=0).
- collision in IDLE or HIT: ignored, never latched.
- Reset mid-flight: bullet vanishes next cycle and no hit_pulse is generated.
- A launch and a hit cannot occur in the same frame.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package space_invaders_pkg holds:
  - bullet_state_t enum {IDLE, FLYING, HIT}.
  - SCREEN_W=640, SCREEN_H=480.
  - BULLET_LEN_DEFAULT=4, shared with color_mapper so drawn and logical lengths match.
- One sub-module, frame_tick_gen: 2-flop synchronizer plus rising-edge detect on frame_clk, reset synchronous.
- The FSM, counters and latches stay in bullet_controller.

Test Plan:
- Reset with fire=1 and frame_clk toggling, then release Reset → bullet_in=0 and hit_count=0 until the first frame_tick after release.
- playerX=300, playerY=440, pulse fire between ticks → next tick launches: bulletX=308, bulletY=436, bullet_in=1. The next three ticks give bulletY = 432, 428, 424.
- Launch at playerY=10 (bulletY=6) → next tick bulletY=2; the following tick returns to IDLE, bullet_in=0, no hit_pulse, hit_count unchanged.
- In FLYING, assert collision for 1 Clk mid-frame → at the next tick bullet_in=0, one hit_pulse, hit_count=1. Fire held is then ignored for 2 ticks; the launch occurs on the 3rd tick.
- Collision asserted exactly on the frame_tick cycle → counted as a hit; collision asserted in IDLE → no latch, no pulse.
- Preload hit_count=255 via 255 hits → one more hit keeps hit_count=255 while hit_pulse still fires. Assert Reset during FLYING → next cycle bullet_in=0 and hit_count=0.
